// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: default widths, fare and the
// 3-bit controller state encoding.
// Latency / backpressure: not applicable (types and constants only).
package coin_acceptor_pkg;

   localparam int VAL_W_DEF    = 8;
   localparam int PRICE_DEF    = 25;
   localparam int CREDIT_W_DEF = VAL_W_DEF + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COLLECT   = 3'd1,
      GRANT     = 3'd2,
      REFUND    = 3'd3,
      WAIT_PASS = 3'd4
   } state_t;

endpackage

// File: rtl/coin_acceptor.sv
// Purpose: accumulate coin credit, issue a one-cycle grant pulse to the turnstile
//   at PRICE, return overpayment/cancelled credit, then wait for unlock->lock passage.
// Latency: final coin to coin pulse 1 cycle; cancel to change_valid 1 cycle.
// Backpressure: coin_ready is low outside IDLE/COLLECT (coins stall, never lost);
//   change_valid/change_value hold until change_ready.
// Ports: clk, rst_n (async active-low); coin_valid/coin_value/coin_ready coin
//   handshake; cancel abort; coin grant pulse out; unlock/lock turnstile status in;
//   change_valid/change_value/change_ready refund handshake; credit registered out.
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int VAL_W    = VAL_W_DEF,
   parameter int PRICE    = PRICE_DEF,
   parameter int CREDIT_W = VAL_W + 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [VAL_W-1:0]    coin_value,
   output logic                coin_ready,
   input  logic                cancel,
   output logic                coin,
   input  logic                unlock,
   input  logic                lock,
   output logic                change_valid,
   output logic [VAL_W-1:0]    change_value,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] credit
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [CREDIT_W-1:0] sum;
   logic [VAL_W-1:0]    change_value_nxt;
   logic                pass_pend, pass_pend_nxt;
   logic                unlock_seen, unlock_seen_nxt;
   logic                acc;

   always_comb begin
      state_nxt        = state;
      credit_nxt       = credit;
      change_value_nxt = change_value;
      pass_pend_nxt    = pass_pend;
      unlock_seen_nxt  = unlock_seen;
      coin_ready       = ((state == IDLE) || (state == COLLECT)) && !cancel;
      acc              = coin_valid && coin_ready;
      sum              = credit + CREDIT_W'(coin_value);

      // Catches both turnstile flavours: a Mealy unlock lands in GRANT together
      // with the coin pulse, a Moore unlock one cycle later.
      if (((state == GRANT) || (state == REFUND) || (state == WAIT_PASS))
          && pass_pend && unlock)
         unlock_seen_nxt = 1'b1;

      case (state)
         IDLE, COLLECT: begin
            // coin_ready is already low under cancel, so cancel wins over a coin.
            if ((state == COLLECT) && cancel) begin
               state_nxt        = REFUND;
               change_value_nxt = VAL_W'(credit);
               credit_nxt       = '0;
               pass_pend_nxt    = 1'b0;
            end else if (acc) begin
               if (sum >= PRICE_C) begin
                  state_nxt        = GRANT;
                  // credit < PRICE, so the overpayment always fits in VAL_W bits.
                  change_value_nxt = VAL_W'(sum - PRICE_C);
                  credit_nxt       = '0;
                  pass_pend_nxt    = 1'b1;
               end else begin
                  state_nxt  = COLLECT;
                  credit_nxt = sum;
               end
            end
         end
         GRANT: begin
            state_nxt = (change_value != '0) ? REFUND : WAIT_PASS;
         end
         REFUND: begin
            if (change_ready)
               state_nxt = pass_pend ? WAIT_PASS : IDLE;
         end
         WAIT_PASS: begin
            // A lock seen before the unlock is the turnstile's idle state, not a passage.
            if (unlock_seen && lock) begin
               state_nxt     = IDLE;
               credit_nxt    = '0;
               pass_pend_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state_nxt == IDLE)
         unlock_seen_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         credit       <= '0;
         coin         <= 1'b0;
         change_valid <= 1'b0;
         change_value <= '0;
         pass_pend    <= 1'b0;
         unlock_seen  <= 1'b0;
      end else begin
         state        <= state_nxt;
         credit       <= credit_nxt;
         change_value <= change_value_nxt;
         pass_pend    <= pass_pend_nxt;
         unlock_seen  <= unlock_seen_nxt;
         // Outputs are registered decodes of the next state.
         coin         <= (state_nxt == GRANT);
         change_valid <= (state_nxt == REFUND);
      end
   end

endmodule
